// File: rtl/alu_arbiter.sv
// Round-robin (or fixed-priority with ALU_ARB_FIXED_PRIO_EN) arbiter that
// shares one combinational ALU between two valid/ready requesters.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_aluop,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_aluop,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [OP_W-1:0]   alu_aluop,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

  state_t            r_state, w_state_nxt;
  logic              r_owner;
  logic              w_grant0, w_grant1, w_accept;
  req_t              r_alu, w_req_sel;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_zero;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_grant0 = req0_valid;
`else
  logic r_last_grant;

  // Ties go to whoever was not served last; single requests always win.
  assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);

  always_ff @(posedge clk) begin
    if (!reset_n)      r_last_grant <= 1'b1;
    else if (w_accept) r_last_grant <= w_grant1;
  end
`endif

  assign w_grant1  = req1_valid && !w_grant0;
  assign w_req_sel = w_grant0 ? req_t'{req0_aluop, req0_a, req0_b}
                              : req_t'{req1_aluop, req1_a, req1_b};

  // Handshake outputs are gated by reset_n so nothing fires while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = reset_n && w_grant0;
        req1_ready = reset_n && w_grant1;
        w_accept   = reset_n && (w_grant0 || w_grant1);
        if (w_accept) w_state_nxt = EXEC;
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        rsp0_valid = reset_n && !r_owner;
        rsp1_valid = reset_n &&  r_owner;
        if (r_owner ? rsp1_ready : rsp0_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_alu        <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_alu   <= w_req_sel;
        r_owner <= w_grant1;
      end
      if (r_state == EXEC) begin
        r_rsp_result <= alu_result;
        r_rsp_zero   <= alu_zero;
      end
    end
  end

  assign alu_aluop  = r_alu.op;
  assign alu_a      = r_alu.a;
  assign alu_b      = r_alu.b;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign busy       = (r_state != IDLE);

endmodule
